// File: rtl/link_credit_pkg.sv
// Shared widths and output-stage state for the link credit arbiter.
// Imported by link_rr_arb and link_credit_arbiter.
package link_credit_pkg;

  function automatic int ch_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int cr_w(input int c);
    return $clog2(c + 1);
  endfunction

  typedef enum logic {
    OS_IDLE = 1'b0,
    OS_FULL = 1'b1
  } os_state_e;

endpackage

// File: rtl/link_rr_arb.sv
// Rotating-priority arbiter: first request at or after i_ptr wins.
// Produces one-hot grant, its index and a valid flag.
module link_rr_arb
  import link_credit_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CH_W   = ch_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [CH_W-1:0]   i_ptr,
  input  logic              i_en,
  output logic [NUM_CH-1:0] o_gnt,
  output logic [CH_W-1:0]   o_id,
  output logic              o_v
);

  always_comb begin
    int k;
    o_gnt = '0;
    o_id  = '0;
    o_v   = 1'b0;
    k     = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      k = (int'(i_ptr) + i) % NUM_CH;
      if (i_en && !o_v && i_req[k]) begin
        o_gnt[k] = 1'b1;
        o_id     = CH_W'(k);
        o_v      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/link_credit_arbiter.sv
// Credit-based round-robin scheduler for a shared upstream link.
// Optional overflow flag/assertion: LINK_CREDIT_ARB_ERR_EN.
module link_credit_arbiter
  import link_credit_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int WIDTH       = 16,
  parameter int CREDITS     = 16,
  parameter int TOKEN_DECIM = 4,
  localparam int CH_W       = ch_w(NUM_CH),
  localparam int CR_W       = cr_w(CREDITS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CH-1:0]      req_v_i,
  input  logic [NUM_CH*WIDTH-1:0] req_data_i,
  output logic [NUM_CH-1:0]      req_yumi_o,
  input  logic [NUM_CH-1:0]      token_i,
  output logic                   link_v_o,
  output logic [WIDTH-1:0]       link_data_o,
  output logic [CH_W-1:0]        link_ch_o,
  input  logic                   link_ready_i,
  output logic [NUM_CH*CR_W-1:0] credit_o,
  output logic                   err_o
);

  localparam int SUM_W = cr_w(CREDITS + TOKEN_DECIM);

  os_state_e         r_state;
  os_state_e         w_state_nxt;
  logic [CR_W-1:0]   r_credit     [NUM_CH];
  logic [CR_W-1:0]   w_credit_nxt [NUM_CH];
  logic [SUM_W-1:0]  w_sum        [NUM_CH];
  logic [NUM_CH-1:0] w_sat;
  logic [NUM_CH-1:0] w_nz;
  logic [NUM_CH-1:0] w_elig;
  logic [NUM_CH-1:0] w_gnt;
  logic [CH_W-1:0]   w_gid;
  logic              w_gv;
  logic              w_slot_free;
  logic [WIDTH-1:0]  w_gdata;
  logic [CH_W-1:0]   r_ptr;
  logic [WIDTH-1:0]  r_data;
  logic [CH_W-1:0]   r_ch;

  assign w_slot_free = (r_state == OS_IDLE) || link_ready_i;

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      w_nz[k]   = (r_credit[k] != '0);
      w_elig[k] = req_v_i[k] && w_nz[k];
    end
  end

  // Reset gates the arbiter so no consume strobe escapes during rst.
  link_rr_arb #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .i_req (w_elig),
    .i_ptr (r_ptr),
    .i_en  (w_slot_free && !rst),
    .o_gnt (w_gnt),
    .o_id  (w_gid),
    .o_v   (w_gv)
  );

  assign req_yumi_o = w_gnt;

  always_comb begin
    w_gdata = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_gnt[k]) begin
        w_gdata = req_data_i[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      OS_IDLE: if (w_gv) w_state_nxt = OS_FULL;
      OS_FULL: if (link_ready_i && !w_gv) w_state_nxt = OS_IDLE;
    endcase
  end

  // Token and grant land in the same cycle; excess beyond CREDITS clips.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      w_sum[k] = SUM_W'(r_credit[k])
               + (token_i[k] ? SUM_W'(TOKEN_DECIM) : SUM_W'(0))
               - (w_gnt[k] ? SUM_W'(1) : SUM_W'(0));
      w_sat[k] = (w_sum[k] > SUM_W'(CREDITS));
      w_credit_nxt[k] = w_sat[k] ? CR_W'(CREDITS)
                                 : w_sum[k][CR_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= OS_IDLE;
      r_data  <= '0;
      r_ch    <= '0;
      r_ptr   <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        r_credit[k] <= CR_W'(CREDITS);
      end
    end else begin
      r_state <= w_state_nxt;
      for (int k = 0; k < NUM_CH; k++) begin
        r_credit[k] <= w_credit_nxt[k];
      end
      if (w_gv) begin
        r_data <= w_gdata;
        r_ch   <= w_gid;
        r_ptr  <= (w_gid == CH_W'(NUM_CH - 1)) ? '0
                                               : w_gid + 1'b1;
      end
    end
  end

  assign link_v_o    = (r_state == OS_FULL);
  assign link_data_o = r_data;
  assign link_ch_o   = r_ch;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_cr
    assign credit_o[k*CR_W +: CR_W] = r_credit[k];
  end

`ifdef LINK_CREDIT_ARB_ERR_EN
  logic r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (|w_sat) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ((w_gnt & ~w_nz) == '0);
    end
  end
`else
  assign err_o = 1'b0;
`endif

endmodule
